pursuit_y_mem_responder: RTL
============================

Name: pursuit_y_mem_responder

Overview:
- Memory-side responder for the pursuit signal (y) bus. Holds the measurement vector y and serves the pursuit engine's read/write port with 1-cycle registered read latency.
- Also provides a host-side streaming LOAD port (fill y before a pursuit run) and a streaming DUMP port (read back the residual afterwards).
- A small FSM gives the host exclusive access while loading or dumping; the engine port is granted only in IDLE.

Parameters:
- DEPTH, 64 (SIGNAL_SIZE_DEFAULT): number of y samples stored.
- ADDR_W, 10 (SIGNAL_ADDR_WIDTH): address width of the engine port.
- DATA_W, 8 (DATA_BUS_WIDTH): sample width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- bus_we  in  1  engine write enable (pursuit_y_bus_t.write_enable).
- bus_raddr  in  ADDR_W  engine read address.
- bus_waddr  in  ADDR_W  engine write address.
- bus_wdata  in  DATA_W  engine write data.
- bus_rdata  out  DATA_W  engine read data, registered.
- bus_grant  out  1  high when the engine port is serviced (IDLE).
- ld_start  in  1  start-load pulse.
- ld_len  in  ADDR_W+1  number of samples to load/dump.
- ld_valid  in  1  load beat valid.
- ld_ready  out  1  load beat accepted.
- ld_data  in  DATA_W  load sample.
- dump_start  in  1  start-dump pulse; uses ld_len.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  dump beat consumed.
- dump_data  out  DATA_W  dump sample.
- dump_last  out  1  marks the final dump beat.
- done  out  1  one-cycle pulse when a load or dump completes.
- oor_err  out  1  sticky flag for an out-of-range engine access.
- err_clr  in  1  clears oor_err.

Behaviour:
- Reset: state IDLE; pointers 0; all outputs 0 except bus_grant=1. Storage contents are not reset.
- FSM states: IDLE, LOAD, DUMP.
- IDLE -> LOAD: on ld_start with ld_len!=0.
- IDLE -> DUMP: on dump_start with ld_len!=0.
- Simultaneous ld_start and dump_start in IDLE: LOAD wins.
- ld_len=0: start is ignored. ld_len>DEPTH: latched value is clamped to DEPTH. Starts outside IDLE are ignored.
- IDLE engine port:
  - Every cycle, bus_rdata <= mem[bus_raddr] (1-cycle latency); returns 0 if bus_raddr>=DEPTH.
  - If bus_we and bus_waddr<DEPTH: mem[bus_waddr] <= bus_wdata.
  - Read and write to the same address in the same cycle returns the old data.
  - Any out-of-range access (read or write) drops the access and sets oor_err.
  - oor_err stays set until an err_clr cycle. If err_clr and a new error occur in the same cycle, the error wins (flag set).
- LOAD / DUMP engine port: bus_grant=0; engine writes are ignored; bus_rdata holds its last value; no errors are flagged.
- LOAD:
  - ld_ready=1 for the whole state.
  - Each ld_valid&&ld_ready writes mem[ptr] <= ld_data and increments ptr.
  - On the len-th beat: next state IDLE, done=1 the following cycle, ld_ready drops the cycle after the last beat.
- DUMP:
  - Entry cycle: dump_data <= mem[0], dump_valid=1 from the next cycle.
  - On dump_valid&&dump_ready: ptr++ and dump_data <= mem[ptr+1]. Without dump_ready, dump_valid and dump_data hold stable.
  - dump_last=1 while presenting index len-1.
  - Handshake on the last beat: dump_valid=0, go to IDLE, done pulses.
  - Throughput: 1 beat/cycle with dump_ready held high.
- Pointer width is ADDR_W+1. Pointers never wrap because len<=DEPTH.
- Asynchronous reset mid-operation aborts to IDLE. Partially loaded data remains in storage.

Decomposition:
- Shared package additions:
  - enum typedef pursuit_mem_state_t {IDLE, LOAD, DUMP}.
  - Constant Y_LEN_WIDTH = SIGNAL_ADDR_WIDTH+1.
- Existing constants reused: SIGNAL_SIZE_DEFAULT, SIGNAL_ADDR_WIDTH, DATA_BUS_WIDTH.
- One sub-module: pursuit_reg_ram. DEPTH x DATA_W register array with one synchronous write port and two combinational read ports (engine, dump).
- The same sub-module is reusable for later x and dict responders.

Test Plan:
- Load and dump round trip:
  - Stimulus: ld_start, ld_len=64, stream 0..63 back-to-back.
  - Response: done pulses 1 cycle after the 64th beat. dump_start then yields 0..63 on consecutive cycles with dump_ready=1, dump_last on value 63, then done.
- Engine port latency:
  - Stimulus: in IDLE, write 0xA5 to addr 5, then read addr 5.
  - Response: bus_rdata=0xA5 one cycle after raddr is presented. A same-cycle read+write to addr 5 with 0x3C returns 0xA5, and the next read returns 0x3C.
- Out-of-range access:
  - Stimulus: write addr 64 with 0xFF, read addr 100.
  - Response: mem unchanged, bus_rdata=0, oor_err=1 and sticky. err_clr clears it. Simultaneous err_clr and a new error leaves oor_err=1.
- Arbitration:
  - Stimulus: during LOAD (ld_len=8), engine writes addr 2 with 0x77.
  - Response: bus_grant=0, write ignored, mem[2] equals the loaded value. Simultaneous ld_start and dump_start enters LOAD.
- Dump backpressure:
  - Stimulus: dump ld_len=4, dump_ready toggled 1,0,0,1,1,0,1.
  - Response: dump_data is stable while stalled, exactly 4 beats are transferred in order, dump_last only on the 4th.
- Boundaries and reset:
  - Stimulus: ld_len=0 start; ld_len=200 load; assert rst_n low after 10 load beats.
  - Response: ld_len=0 is ignored. ld_len=200 completes after exactly 64 beats. On reset all outputs go to 0 except bus_grant=1, state IDLE, mem[0..9] retain the loaded values.

Source files
------------

// File: rtl/pursuit_y_mem_responder_pkg.sv
// Shared constants and types for the pursuit memory responders (y now, x and dict later).
package pursuit_y_mem_responder_pkg;

    localparam int SIGNAL_SIZE_DEFAULT = 64;
    localparam int SIGNAL_ADDR_WIDTH   = 10;
    localparam int DATA_BUS_WIDTH      = 8;
    localparam int Y_LEN_WIDTH         = SIGNAL_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DUMP = 2'd2
    } pursuit_mem_state_t;

endpackage

// File: rtl/pursuit_y_mem_responder_reg_ram.sv
// DEPTH x DATA_W register array: one synchronous write port, two combinational read ports.
module pursuit_reg_ram #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [IDX_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage is deliberately not reset so partially loaded data survives an abort.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_r[raddr_a];
    assign rdata_b = mem_r[raddr_b];

endmodule

// File: rtl/pursuit_y_mem_responder.sv
// y-vector memory responder: engine read/write port while IDLE, host load/dump streams otherwise.
module pursuit_y_mem_responder
    import pursuit_y_mem_responder_pkg::*;
#(
    parameter int DEPTH  = SIGNAL_SIZE_DEFAULT,
    parameter int ADDR_W = SIGNAL_ADDR_WIDTH,
    parameter int DATA_W = DATA_BUS_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_raddr,
    input  logic [ADDR_W-1:0] bus_waddr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_grant,
    input  logic              ld_start,
    input  logic [ADDR_W:0]   ld_len,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              done,
    output logic              oor_err,
    input  logic              err_clr
);
    localparam int LEN_W = ADDR_W + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

    pursuit_mem_state_t state_r, state_nxt_s;
    logic [LEN_W-1:0]  ptr_r, ptr_nxt_s, len_r, len_nxt_s;
    logic [LEN_W-1:0]  ptr_inc_s, last_idx_s, start_len_s;
    logic              idle_s, rd_oor_s, wr_oor_s, go_load_s, go_dump_s;
    logic              ld_beat_s, ld_last_s, dump_beat_s, dump_fin_s;
    logic              ram_we_s;
    logic [IDX_W-1:0]  ram_waddr_s, dump_idx_s;
    logic [DATA_W-1:0] ram_wdata_s, eng_rd_s, dump_rd_s;
    logic [DATA_W-1:0] bus_rdata_r, bus_rdata_nxt_s, dump_data_r, dump_data_nxt_s;
    logic              bus_grant_r, bus_grant_nxt_s, ld_ready_r, ld_ready_nxt_s;
    logic              dump_valid_r, dump_valid_nxt_s, dump_last_r, dump_last_nxt_s;
    logic              done_r, done_nxt_s, oor_err_r, oor_err_nxt_s;

    assign idle_s      = (state_r == IDLE);
    assign rd_oor_s    = ({1'b0, bus_raddr} >= DEPTH_L);
    assign wr_oor_s    = bus_we && ({1'b0, bus_waddr} >= DEPTH_L);
    assign start_len_s = (ld_len > DEPTH_L) ? DEPTH_L : ld_len;
    assign go_load_s   = idle_s && ld_start && (ld_len != '0);
    assign go_dump_s   = idle_s && !go_load_s && dump_start && (ld_len != '0);
    assign ptr_inc_s   = ptr_r + ONE_L;
    assign last_idx_s  = len_r - ONE_L;
    assign ld_beat_s   = (state_r == LOAD) && ld_valid;
    assign ld_last_s   = ld_beat_s && (ptr_r == last_idx_s);
    assign dump_beat_s = (state_r == DUMP) && dump_valid_r && dump_ready;
    assign dump_fin_s  = dump_beat_s && (ptr_r == last_idx_s);
    // Dump port pre-reads the next sample so a handshake can advance every cycle.
    assign dump_idx_s  = (state_r == DUMP) ? ptr_inc_s[IDX_W-1:0] : '0;

    pursuit_reg_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we_s),
        .waddr   (ram_waddr_s),
        .wdata   (ram_wdata_s),
        .raddr_a (bus_raddr[IDX_W-1:0]),
        .rdata_a (eng_rd_s),
        .raddr_b (dump_idx_s),
        .rdata_b (dump_rd_s)
    );

    // Write-port arbitration: engine only while IDLE, load stream only while LOAD.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = '0;
        ram_wdata_s = '0;
        if (idle_s && bus_we && !wr_oor_s) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = bus_waddr[IDX_W-1:0];
            ram_wdata_s = bus_wdata;
        end else if (ld_beat_s) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = ptr_r[IDX_W-1:0];
            ram_wdata_s = ld_data;
        end else begin
            ram_we_s    = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; LOAD takes priority over DUMP on simultaneous starts.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (go_load_s) begin
                    state_nxt_s = LOAD;
                end else if (go_dump_s) begin
                    state_nxt_s = DUMP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD:    state_nxt_s = ld_last_s  ? IDLE : LOAD;
            DUMP:    state_nxt_s = dump_fin_s ? IDLE : DUMP;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output and datapath next values; every output leaves the block registered.
    always_comb begin
        bus_grant_nxt_s  = (state_nxt_s == IDLE);
        ld_ready_nxt_s   = (state_nxt_s == LOAD);
        done_nxt_s       = ld_last_s | dump_fin_s;
        bus_rdata_nxt_s  = bus_rdata_r;
        oor_err_nxt_s    = oor_err_r;
        dump_valid_nxt_s = dump_valid_r;
        dump_data_nxt_s  = dump_data_r;
        dump_last_nxt_s  = dump_last_r;
        ptr_nxt_s        = ptr_r;
        len_nxt_s        = len_r;

        if (idle_s) begin
            bus_rdata_nxt_s = rd_oor_s ? '0 : eng_rd_s;
        end else begin
            bus_rdata_nxt_s = bus_rdata_r;
        end

        // A fresh error outranks a clear in the same cycle.
        if (idle_s && (rd_oor_s || wr_oor_s)) begin
            oor_err_nxt_s = 1'b1;
        end else if (err_clr) begin
            oor_err_nxt_s = 1'b0;
        end else begin
            oor_err_nxt_s = oor_err_r;
        end

        if (go_load_s || go_dump_s) begin
            ptr_nxt_s = '0;
            len_nxt_s = start_len_s;
        end else if (ld_beat_s || dump_beat_s) begin
            ptr_nxt_s = ptr_inc_s;
        end else begin
            ptr_nxt_s = ptr_r;
        end

        if (go_dump_s) begin
            dump_valid_nxt_s = 1'b1;
            dump_data_nxt_s  = dump_rd_s;
            dump_last_nxt_s  = (start_len_s == ONE_L);
        end else if (dump_fin_s) begin
            dump_valid_nxt_s = 1'b0;
            dump_last_nxt_s  = 1'b0;
        end else if (dump_beat_s) begin
            dump_data_nxt_s  = dump_rd_s;
            dump_last_nxt_s  = (ptr_inc_s == last_idx_s);
        end else begin
            dump_valid_nxt_s = dump_valid_r;
        end
    end

    // Output and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_rdata_r  <= '0;
            bus_grant_r  <= 1'b1;
            ld_ready_r   <= 1'b0;
            dump_valid_r <= 1'b0;
            dump_data_r  <= '0;
            dump_last_r  <= 1'b0;
            done_r       <= 1'b0;
            oor_err_r    <= 1'b0;
            ptr_r        <= '0;
            len_r        <= '0;
        end else begin
            bus_rdata_r  <= bus_rdata_nxt_s;
            bus_grant_r  <= bus_grant_nxt_s;
            ld_ready_r   <= ld_ready_nxt_s;
            dump_valid_r <= dump_valid_nxt_s;
            dump_data_r  <= dump_data_nxt_s;
            dump_last_r  <= dump_last_nxt_s;
            done_r       <= done_nxt_s;
            oor_err_r    <= oor_err_nxt_s;
            ptr_r        <= ptr_nxt_s;
            len_r        <= len_nxt_s;
        end
    end

    assign bus_rdata  = bus_rdata_r;
    assign bus_grant  = bus_grant_r;
    assign ld_ready   = ld_ready_r;
    assign dump_valid = dump_valid_r;
    assign dump_data  = dump_data_r;
    assign dump_last  = dump_last_r;
    assign done       = done_r;
    assign oor_err    = oor_err_r;

endmodule
